// File: rtl/onchip_rom_loader_pkg.sv
// Shared types and constants for the on-chip ROM loader.
package onchip_rom_loader_pkg;

    localparam int ROM_ADDR_W = 9;
    localparam int ROM_DATA_W = 16;
    localparam int ROM_DEPTH  = 512;

    localparam logic [1:0] ROM_BYTEENABLE = 2'b11;

    typedef enum logic [3:0] {
        IDLE,
        HDR_LO,
        HDR_HI,
        DATA_LO,
        DATA_HI,
        WRITE,
        VERIFY,
        DONE,
        ERROR
    } state_t;

endpackage

// File: rtl/onchip_rom_loader.sv
// Byte-stream loader for the program ROM debug write port: header parse, LE word assembly, checksum.
// Optional read-back verification is compiled in with ROM_LOADER_VERIFY_EN.
module onchip_rom_loader
    import onchip_rom_loader_pkg::*;
#(
    parameter int ADDR_W = ROM_ADDR_W,
    parameter int DATA_W = ROM_DATA_W,
    parameter int DEPTH  = ROM_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] rom_address,
    output logic [1:0]        rom_byteenable,
    output logic              rom_chipselect,
    output logic              rom_write,
    output logic              rom_debugaccess,
    output logic [DATA_W-1:0] rom_writedata,
    output logic              rom_clken,
    input  logic [DATA_W-1:0] rom_readdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   word_count,
    output logic [DATA_W-1:0] checksum
);

    localparam int CNT_W = ADDR_W + 1;

    state_t state, state_next;

    logic [7:0]       hdr_lo;
    logic [7:0]       lo_byte;
    logic [15:0]      hdr_word;
    logic [CNT_W-1:0] n_q;
    logic             hdr_bad;
    logic             last_word;
    logic             cs_d;
    logic             wr_d;

    assign hdr_word  = {in_data, hdr_lo};
    assign hdr_bad   = (hdr_word == '0) || (32'(hdr_word) > DEPTH);
    assign last_word = (word_count + CNT_W'(1)) == n_q;

    assign rom_byteenable = ROM_BYTEENABLE;
    assign rom_clken      = 1'b1;

`ifdef ROM_LOADER_VERIFY_EN
    logic [CNT_W-1:0]  vcnt;
    logic [DATA_W-1:0] vsum;
    logic              verify_last;
    logic              sums_match;

    // Cycle k presents address k; the word read at cycle k-1 arrives now, so cycle N closes the sum.
    assign verify_last = vcnt == n_q;
    assign sums_match  = (vsum + rom_readdata) == checksum;
`else
    logic unused_readdata;
    assign unused_readdata = ^rom_readdata;
`endif

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: state_next is defaulted first so no path through the case can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = HDR_LO;
            HDR_LO:  if (in_valid) state_next = HDR_HI;
            HDR_HI:  if (in_valid) state_next = hdr_bad ? ERROR : DATA_LO;
            DATA_LO: if (in_valid) state_next = DATA_HI;
            DATA_HI: if (in_valid) state_next = WRITE;
`ifdef ROM_LOADER_VERIFY_EN
            WRITE:   state_next = last_word ? VERIFY : DATA_LO;
            VERIFY:  if (verify_last) state_next = sums_match ? DONE : ERROR;
`else
            WRITE:   state_next = last_word ? DONE : DATA_LO;
`endif
            DONE:    if (start) state_next = HDR_LO;
            ERROR:   if (start) state_next = HDR_LO;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == HDR_LO) || (state == HDR_HI) ||
                   (state == DATA_LO) || (state == DATA_HI);
        busy     = !((state == IDLE) || (state == DONE) || (state == ERROR));
        done     = state == DONE;
        error    = state == ERROR;
        // ROM strobes are registered from the next state so they line up with WRITE/VERIFY.
        cs_d     = (state_next == WRITE) || (state_next == VERIFY);
        wr_d     = state_next == WRITE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hdr_lo          <= '0;
            lo_byte         <= '0;
            n_q             <= '0;
            word_count      <= '0;
            checksum        <= '0;
            rom_address     <= '0;
            rom_writedata   <= '0;
            rom_chipselect  <= 1'b0;
            rom_write       <= 1'b0;
            rom_debugaccess <= 1'b0;
`ifdef ROM_LOADER_VERIFY_EN
            vcnt            <= '0;
            vsum            <= '0;
`endif
        end else begin
            rom_chipselect  <= cs_d;
            rom_write       <= wr_d;
            rom_debugaccess <= wr_d;
            case (state)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        word_count  <= '0;
                        checksum    <= '0;
                        rom_address <= '0;
                    end
                end
                HDR_LO:  if (in_valid) hdr_lo <= in_data;
                HDR_HI:  if (in_valid) n_q <= CNT_W'(hdr_word);
                DATA_LO: if (in_valid) lo_byte <= in_data;
                DATA_HI: if (in_valid) rom_writedata <= {in_data, lo_byte};
                WRITE: begin
                    checksum   <= checksum + rom_writedata;
                    word_count <= word_count + CNT_W'(1);
`ifdef ROM_LOADER_VERIFY_EN
                    rom_address <= last_word ? '0 : rom_address + ADDR_W'(1);
                    vcnt        <= '0;
                    vsum        <= '0;
`else
                    rom_address <= rom_address + ADDR_W'(1);
`endif
                end
`ifdef ROM_LOADER_VERIFY_EN
                VERIFY: begin
                    rom_address <= rom_address + ADDR_W'(1);
                    vcnt        <= vcnt + CNT_W'(1);
                    if (vcnt != '0) vsum <= vsum + rom_readdata;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_onchip_rom_loader.sv
// Scoreboard bench for onchip_rom_loader; honours ROM_LOADER_VERIFY_EN when defined.
module tb_onchip_rom_loader;

    localparam int ADDR_W = 9;
    localparam int DEPTH  = 512;
`ifdef ROM_LOADER_VERIFY_EN
    localparam bit VERIFY_ON = 1'b1;
`else
    localparam bit VERIFY_ON = 1'b0;
`endif

    typedef logic [15:0] wq_t[$];

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] rom_address;
    logic [1:0]        rom_byteenable;
    logic              rom_chipselect;
    logic              rom_write;
    logic              rom_debugaccess;
    logic [15:0]       rom_writedata;
    logic              rom_clken;
    logic [15:0]       rom_readdata = '0;
    logic              busy;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   word_count;
    logic [15:0]       checksum;

    int total = 0;
    int bad   = 0;

    logic [15:0] mem [DEPTH];
    bit          corrupt_en   = 1'b0;
    int          corrupt_addr = 0;
    logic [31:0] exp_q[$];
    int          cyc      = 0;
    int          wr_seen  = 0;
    int          vcyc     = 0;
    int          wr_cycle[int];

    onchip_rom_loader dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .in_data         (in_data),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .rom_address     (rom_address),
        .rom_byteenable  (rom_byteenable),
        .rom_chipselect  (rom_chipselect),
        .rom_write       (rom_write),
        .rom_debugaccess (rom_debugaccess),
        .rom_writedata   (rom_writedata),
        .rom_clken       (rom_clken),
        .rom_readdata    (rom_readdata),
        .busy            (busy),
        .done            (done),
        .error           (error),
        .word_count      (word_count),
        .checksum        (checksum)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ROM model: synchronous write, registered read, optional single-word corruption on read.
    initial for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    always @(posedge clk) begin
        if (rom_chipselect && rom_write) mem[rom_address] <= rom_writedata;
        if (rom_chipselect)
            rom_readdata <= mem[rom_address] ^
                ((corrupt_en && int'(rom_address) == corrupt_addr) ? 16'h0001 : 16'h0000);
    end

    // Monitor: every write strobe pops one expected {address, data} entry.
    always @(negedge clk) begin
        logic [31:0] exp_w;
        cyc++;
        if (rom_chipselect && !rom_write) vcyc++;
        if (rom_write) begin
            wr_cycle[wr_seen] = cyc;
            wr_seen++;
            exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
            check("write_addr_data", {7'd0, rom_address, rom_writedata}, exp_w);
            check("ready_during_write", {31'd0, in_ready}, 32'd0);
            check("write_qualifiers", {28'd0, rom_chipselect, rom_debugaccess, rom_byteenable}, 32'hF);
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int n = 0;
        if (gaps) begin
            repeat ($urandom_range(0, 3)) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                @(negedge clk);
            end
        end
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("byte_accept_timeout", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic wait_idle(input int max_cycles);
        int n = 0;
        while (busy && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_strobes"}, {28'd0, in_ready, rom_chipselect, rom_write, rom_debugaccess}, 32'd0);
        check({tag, "_addr_wdata"}, {7'd0, rom_address, rom_writedata}, 32'd0);
        check({tag, "_count_sum"}, {6'd0, word_count, checksum}, 32'd0);
        check({tag, "_status"}, {29'd0, busy, done, error}, 32'd0);
        check({tag, "_be_clken"}, {29'd0, rom_byteenable, rom_clken}, 32'h7);
    endtask

    // Reference: header N, words written at 0..N-1, sum mod 2^16; verify fails only on a corrupted read.
    task automatic do_load(input string tag, input logic [15:0] hdr, input wq_t words,
                           input bit gaps, input bit corrupt, input int cidx);
        int          s_wr   = wr_seen;
        int          s_v    = vcyc;
        int          n      = words.size();
        bit          hdr_ok = (hdr != 16'd0) && (int'(hdr) <= DEPTH);
        bit          vfail  = VERIFY_ON && corrupt;
        logic [15:0] sum    = '0;
        corrupt_en   = corrupt;
        corrupt_addr = cidx;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        send_byte(hdr[7:0], gaps);
        send_byte(hdr[15:8], gaps);
        if (!hdr_ok) begin
            check({tag, "_hdr_status"}, {28'd0, in_ready, busy, done, error}, 32'd1);
            repeat (4) @(negedge clk);
            check({tag, "_hdr_no_writes"}, wr_seen - s_wr, 32'd0);
            return;
        end
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({7'd0, 9'(i), words[i]});
            sum = sum + words[i];
            send_byte(words[i][7:0], gaps);
            send_byte(words[i][15:8], gaps);
        end
        wait_idle(4000);
        check({tag, "_done_error"}, {30'd0, done, error}, {30'd0, !vfail, vfail});
        check({tag, "_checksum"}, {16'd0, checksum}, {16'd0, sum});
        check({tag, "_word_count"}, {22'd0, word_count}, 32'(n));
        check({tag, "_writes"}, wr_seen - s_wr, 32'(n));
        check({tag, "_verify_cycles"}, vcyc - s_v, VERIFY_ON ? 32'(n + 1) : 32'd0);
        check({tag, "_queue_empty"}, exp_q.size(), 32'd0);
        if (!gaps && wr_seen > s_wr)
            check({tag, "_throughput"}, wr_cycle[wr_seen - 1] - wr_cycle[s_wr], 32'(3 * (n - 1)));
    endtask

    initial begin
        wq_t plan;
        wq_t rnd;
        wq_t full;
        int  s_wr;

        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        reset = 1'b0;
        @(negedge clk);

        plan = '{16'h1234, 16'hABCD, 16'h0001};
        do_load("plan", 16'd3, plan, 1'b0, 1'b0, 0);
        check("plan_checksum_const", {16'd0, checksum}, 32'h0000_BE02);

        do_load("hdr_zero", 16'h0000, '{}, 1'b0, 1'b0, 0);
        do_load("hdr_513", 16'h0201, '{}, 1'b1, 1'b0, 0);

        do_load("corrupt", 16'd3, plan, 1'b0, 1'b1, 1);

        for (int r = 0; r < 3; r++) begin
            int n = $urandom_range(1, 24);
            rnd = {};
            for (int i = 0; i < n; i++) rnd.push_back(16'($urandom));
            do_load("rnd_b2b", 16'(n), rnd, 1'b0, 1'b0, 0);
            do_load("rnd_gaps", 16'(n), rnd, 1'b1, 1'b0, 0);
        end

        // Reset while the high byte of the second word is on the bus.
        s_wr = wr_seen;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        send_byte(8'h03, 1'b0);
        send_byte(8'h00, 1'b0);
        exp_q.push_back({7'd0, 9'd0, 16'hC0DE});
        send_byte(8'hDE, 1'b0);
        send_byte(8'hC0, 1'b0);
        send_byte(8'h55, 1'b0);
        in_valid = 1'b1;
        in_data  = 8'hAA;
        reset    = 1'b1;
        @(negedge clk);
        check_reset_vals("midreset");
        reset    = 1'b0;
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        check("midreset_writes", wr_seen - s_wr, 32'd1);
        do_load("post_reset", 16'd3, plan, 1'b1, 1'b0, 0);

        full = {};
        for (int i = 0; i < DEPTH; i++) full.push_back(16'hFFFF);
        do_load("full", 16'(DEPTH), full, 1'b0, 1'b0, 0);
        check("full_checksum_const", {16'd0, checksum}, 32'h0000_FE00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
